// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, opcode constants and FSM encoding.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 12;

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and decode; synchronous write, flush clears all entries.
// Pointers carry one extra bit so occupancy (wptr - rptr) distinguishes full from empty.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 44
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW:0]   w_count;

  assign w_count = r_wptr - r_rptr;
  assign o_count = w_count;
  assign o_valid = (w_count != '0);
  // Head reads as zero when empty so outputs are clean straight out of reset.
  assign o_head  = o_valid ? r_mem[r_rptr[PW-1:0]] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wptr[PW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads, queues returned words and applies redirects.
// Decode handshake: the head moves only when inst_valid & inst_ready; otherwise data/pc hold stable.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic              redirect_is_rel,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [31:0]       redirect_imm,
  output fetch_state_t      dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t        r_state;
  fetch_state_t        w_state_nx;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nx;
  logic [ADDR_W-1:0]   r_req_pc;
  logic [ADDR_W-1:0]   w_target;
  logic                r_pend;
  logic                r_drop;
  logic                w_inflight;
  logic                w_pop;
  logic                w_push;
  logic                w_en;
  logic                w_slot_free;
  logic [CW-1:0]       w_count;
  logic [CW:0]         w_need;
  logic [31+ADDR_W:0]  w_head;
  logic                w_unused;

  assign w_unused = ^redirect_imm[31:ADDR_W];

  assign w_target = redirect_is_rel ? (redirect_pc + ADDR_W'(1) + redirect_imm[ADDR_W-1:0])
                                    : redirect_imm[ADDR_W-1:0];

  // A response whose request was issued in a redirect cycle belongs to the old path.
  assign w_inflight  = r_pend & ~r_drop;
  assign w_pop       = inst_valid & inst_ready;
  assign w_push      = w_inflight & ~redirect_valid;
  assign w_need      = {1'b0, w_count} + (CW+1)'(w_inflight) - (CW+1)'(w_pop);
  assign w_slot_free = (w_need < (CW+1)'(DEPTH));

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_en       = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nx = ST_RUN;
      ST_RUN: begin
        if (w_slot_free) begin
          w_en    = 1'b1;
          w_pc_nx = r_pc + ADDR_W'(1);
        end else begin
          w_state_nx = ST_FULL;
        end
      end
      ST_FULL: if (w_slot_free) w_state_nx = ST_RUN;
      default: w_state_nx = ST_BOOT;
    endcase
    if (redirect_valid) begin
      w_state_nx = ST_RUN;
      w_pc_nx    = w_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_pend   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_pend  <= w_en;
      r_drop  <= redirect_valid & w_en;
      if (w_en) r_req_pc <= r_pc;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (32 + ADDR_W)
  ) u_queue (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data ({imem_data, r_req_pc}),
    .i_pop       (w_pop),
    .o_valid     (inst_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign imem_en   = w_en;
  assign imem_addr = w_en ? r_pc : '0;
  assign inst_data = w_head[ADDR_W +: 32];
  assign inst_pc   = w_head[ADDR_W-1:0];
  assign dbg_state = r_state;

endmodule
